// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared states, opcodes, ALU codes and mux selects for the multi-cycle controller
package ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, HALT
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  function automatic logic [1:0] imm_of(input logic [6:0] op);
    return op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields, memory handshake and datapath controls between sequencer and datapath
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] imm_src;
  logic [1:0] result_src;
  logic       reg_write;
  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output mem_read, mem_write, adr_src, ir_write, pc_write,
           alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, reg_write
  );
  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  mem_read, mem_write, adr_src, ir_write, pc_write,
           alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, reg_write
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: maps funct3/funct7b5 to an ALU operation and flags unsupported funct3 codes
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);
  always_comb begin
    alu_ctrl = funct3 == 3'b000 ? ((is_rtype && funct7b5) ? ALU_SUB : ALU_ADD) :
               funct3 == 3'b010 ? ALU_SLT :
               funct3 == 3'b110 ? ALU_OR  :
               funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    illegal  = !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer driving datapath selects and stalling on a shared memory port
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_if.master     bus,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] retired
);
  state_t state, next;
  logic [2:0] dec_ctrl;
  logic       dec_illegal;
  logic       bad_instr;
  state_t     decode_next;
  logic       retire;
  alu_decoder u_alu_decoder (
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .is_rtype (bus.opcode == OP_R),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );
  always_comb begin
    bad_instr   = bus.opcode inside {OP_LOAD, OP_STORE, OP_JAL} ? 1'b0 :
                  bus.opcode inside {OP_R, OP_I} ? dec_illegal :
                  bus.opcode == OP_BRANCH ? bus.funct3[2:1] != 2'b00 : 1'b1;
    decode_next = bad_instr ? (HALT_ON_ILLEGAL ? HALT : FETCH) :
                  bus.opcode inside {OP_LOAD, OP_STORE} ? MEMADR :
                  bus.opcode == OP_R ? EXECR :
                  bus.opcode == OP_I ? EXECI :
                  bus.opcode == OP_BRANCH ? BRANCH : JAL;
  end
  always_comb begin
    next           = state;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.alu_ctrl   = ALU_ADD;
    bus.result_src = RES_ALUOUT;
    bus.reg_write  = 1'b0;
    bus.imm_src    = imm_of(bus.opcode);
    halted         = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_read   = 1'b1;
        bus.alu_src_b  = SRC_B_FOUR;
        bus.result_src = RES_ALU;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
        next           = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_a = SRC_A_OLDPC;
        bus.alu_src_b = SRC_B_IMM;
        next          = decode_next;
      end
      MEMADR: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
        next          = bus.opcode == OP_LOAD ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.mem_read = 1'b1;
        bus.adr_src  = 1'b1;
        next         = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.result_src = RES_MEM;
        bus.reg_write  = 1'b1;
        next           = FETCH;
      end
      MEMWRITE: begin
        bus.mem_write = 1'b1;
        bus.adr_src   = 1'b1;
        next          = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_RS2;
        bus.alu_ctrl  = dec_ctrl;
        next          = ALUWB;
      end
      EXECI: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_ctrl  = dec_ctrl;
        next          = ALUWB;
      end
      ALUWB: begin
        bus.reg_write = 1'b1;
        next          = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_RS2;
        bus.alu_ctrl  = ALU_SUB;
        bus.pc_write  = (bus.funct3 == 3'b000 && bus.zero) || (bus.funct3 == 3'b001 && !bus.zero);
        next          = FETCH;
      end
      JAL: begin
        bus.alu_src_a = SRC_A_OLDPC;
        bus.alu_src_b = SRC_B_FOUR;
        bus.pc_write  = 1'b1;
        next          = ALUWB;
      end
      HALT: halted = 1'b1;
      default: next = FETCH;
    endcase
    if (rst) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.reg_write = 1'b0;
      halted        = 1'b0;
      next          = FETCH;
    end
  end
  assign retire = next == FETCH && state inside {MEMWB, MEMWRITE, ALUWB, BRANCH};
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state   <= next;
      retired <= retired + DATA_WIDTH'(retire);
    end
  end
endmodule
